serial_add_sub: RTL

Bit-serial two's-complement adder/subtractor for the RISC datapath. It takes WIDTH-bit operands and streams them LSB-first through the library's 1-bit full-adder cell, one bit per clock. A carry flip-flop feeds each bit's carry-out back in as the next bit's carry-in. It trades WIDTH cycles of latency for a single adder cell, and reports result, carry, signed overflow and zero flags to the ALU/flag logic downstream.

---
 rtl/serial_alu_pkg.sv | 20 ++
 rtl/serial_add_sub_full_adder.sv | 20 ++
 rtl/serial_add_sub.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// ============================================================================
// serial_alu_pkg : shared state type and operation codes for the serial ALU
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package serial_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_add_sub_full_adder.sv
// ============================================================================
// serial_add_sub_full_adder : library 1-bit full-adder cell (Cin, A, B -> Cout, Out)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module serial_add_sub_full_adder (
   input  logic Cin,
   input  logic A,
   input  logic B,
   output logic Cout,
   output logic Out
);

   assign Out  = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// serial_add_sub : bit-serial two's-complement adder/subtractor, LSB first,
//                  one bit per clock through a single full-adder cell
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module serial_add_sub
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state_q;
   state_t             state_next;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   sum_sr;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt;

   logic               fa_out;
   logic               fa_cout;
   logic               last_bit;
   logic [WIDTH-1:0]   sum_next;
   logic               overflow_next;
   logic               zero_next;

   serial_add_sub_full_adder u_fa (
      .Cin  (carry_q),
      .A    (a_sr[0]),
      .B    (b_sr[0]),
      .Cout (fa_cout),
      .Out  (fa_out)
   );

   // On the last bit the carry FF holds the carry into the MSB.
   always_comb begin
      last_bit      = (cnt == LAST_BIT);
      sum_next      = {fa_out, sum_sr[WIDTH-1:1]};
      overflow_next = carry_q ^ fa_cout;
      zero_next     = (sum_next == '0);
      state_next    = state_q;
      case (state_q)
         IDLE:    if (start)    state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:                  state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         carry_q  <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         state_q <= state_next;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr    <= a;
                  b_sr    <= b ^ {WIDTH{sub}};
                  carry_q <= (sub == OP_SUB);
                  cnt     <= '0;
                  sum_sr  <= '0;
               end
            end
            RUN: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               sum_sr  <= sum_next;
               carry_q <= fa_cout;
               cnt     <= cnt + CNT_W'(1);
               if (last_bit) begin
                  result   <= sum_next;
                  cout     <= fa_cout;
                  overflow <= overflow_next;
                  zero     <= zero_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

`default_nettype wire
